// File: rtl/window_conv_if.sv
//------------------------------------------------------------------------------
// axi4_stream_if : AXI4-Stream video channel (tdata/tvalid/tready/tlast/tuser)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/window_conv.sv
//------------------------------------------------------------------------------
// window_conv : streaming WIN_SIZE x WIN_SIZE convolution with pipelined adder
//               tree, normalize, optional round (WINDOW_CONV_ROUND_EN), saturate.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module window_conv #(
  parameter int WIN_SIZE    = 5,
  parameter int COMP_NUM    = 3,
  parameter int COMP_WIDTH  = 10,
  parameter int PX_WIDTH    = COMP_NUM * COMP_WIDTH,
  parameter int COEF_WIDTH  = 8,
  parameter int NORM_SHIFT  = 4,
  parameter int TDATA_WIDTH = 32
) (
  input  wire logic                                     clk_i,
  input  wire logic                                     rst_i,
  input  wire logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0]  coef_i,
  axi4_stream_if.slave                                  window_i,
  axi4_stream_if.master                                 video_o
);

  localparam int N      = WIN_SIZE * WIN_SIZE;
  localparam int L      = $clog2(N);
  localparam int P      = COMP_WIDTH + 1 + COEF_WIDTH;
  localparam int S      = P + L;
  localparam int DEPTH  = L + 2;
  localparam int RND_SH = (NORM_SHIFT > 0) ? NORM_SHIFT - 1 : 0;
  localparam logic signed [S-1:0] MAX_C = S'((1 << COMP_WIDTH) - 1);
`ifdef WINDOW_CONV_ROUND_EN
  localparam logic signed [S-1:0] RND = (NORM_SHIFT > 0) ? (S'(1) << RND_SH) : S'(0);
`else
  localparam logic signed [S-1:0] RND = S'(0);
`endif

  logic                      en;
  logic [N*COEF_WIDTH-1:0]   coef_q, coef_d, coef_use;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0]          last_q, last_d;
  logic [DEPTH-1:0]          user_q, user_d;
  logic [TDATA_WIDTH-1:0]    tdata_q, tdata_d;
  // Level 0 holds the products, level L index 0 the final sum.
  logic signed [S-1:0]       tree_q [COMP_NUM][L+1][N];
  logic signed [S-1:0]       tree_d [COMP_NUM][L+1][N];

  assign en              = !video_o.tvalid || video_o.tready;
  assign window_i.tready = en;
  assign video_o.tvalid  = valid_q[DEPTH-1];
  assign video_o.tlast   = last_q[DEPTH-1];
  assign video_o.tuser   = user_q[DEPTH-1];
  assign video_o.tdata   = tdata_q;

  always_comb begin : p_ctrl
    coef_use = window_i.tuser ? coef_i : coef_q;
    coef_d   = (window_i.tvalid && window_i.tuser) ? coef_i : coef_q;
    valid_d  = {valid_q[DEPTH-2:0], window_i.tvalid};
    last_d   = {last_q[DEPTH-2:0],  window_i.tlast};
    user_d   = {user_q[DEPTH-2:0],  window_i.tuser};
  end

  always_comb begin : p_tree
    logic signed [COMP_WIDTH:0]   px;
    logic signed [COEF_WIDTH-1:0] cf;
    logic signed [P-1:0]          prod;
    int                           cnt;
    int                           ia;
    int                           ib;
    px   = '0;
    cf   = '0;
    prod = '0;
    cnt  = N;
    ia   = 0;
    ib   = 0;
    for (int c = 0; c < COMP_NUM; c++)
      for (int l = 0; l <= L; l++)
        for (int k = 0; k < N; k++)
          tree_d[c][l][k] = '0;
    for (int c = 0; c < COMP_NUM; c++) begin
      for (int k = 0; k < N; k++) begin
        px   = {1'b0, window_i.tdata[k*PX_WIDTH + c*COMP_WIDTH +: COMP_WIDTH]};
        cf   = coef_use[k*COEF_WIDTH +: COEF_WIDTH];
        prod = P'(px) * P'(cf);
        tree_d[c][0][k] = S'(prod);
      end
      cnt = N;
      // Odd leftover at the end of a level passes straight through.
      for (int l = 1; l <= L; l++) begin
        for (int i = 0; i < N; i++) begin
          ia = (2*i < N)     ? 2*i     : N - 1;
          ib = (2*i + 1 < N) ? 2*i + 1 : N - 1;
          if (2*i + 1 < cnt)
            tree_d[c][l][i] = tree_q[c][l-1][ia] + tree_q[c][l-1][ib];
          else if (2*i < cnt)
            tree_d[c][l][i] = tree_q[c][l-1][ia];
        end
        cnt = (cnt + 1) / 2;
      end
    end
  end

  always_comb begin : p_out
    logic signed [S-1:0]     acc;
    logic [COMP_WIDTH-1:0]   comp;
    acc     = '0;
    comp    = '0;
    tdata_d = '0;
    for (int c = 0; c < COMP_NUM; c++) begin
      acc = (tree_q[c][L][0] + RND) >>> NORM_SHIFT;
      if (acc < 0)
        comp = '0;
      else if (acc > MAX_C)
        comp = MAX_C[COMP_WIDTH-1:0];
      else
        comp = acc[COMP_WIDTH-1:0];
      tdata_d[c*COMP_WIDTH +: COMP_WIDTH] = comp;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      coef_q  <= '0;
      valid_q <= '0;
      last_q  <= '0;
      user_q  <= '0;
      tdata_q <= '0;
      for (int c = 0; c < COMP_NUM; c++)
        for (int l = 0; l <= L; l++)
          for (int k = 0; k < N; k++)
            tree_q[c][l][k] <= '0;
    end else if (en) begin
      coef_q  <= coef_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      user_q  <= user_d;
      tdata_q <= tdata_d;
      for (int c = 0; c < COMP_NUM; c++)
        for (int l = 0; l <= L; l++)
          for (int k = 0; k < N; k++)
            tree_q[c][l][k] <= tree_d[c][l][k];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_conv.sv
//------------------------------------------------------------------------------
// tb_window_conv : scoreboard bench for window_conv (3x3 window, 3x10-bit pixels)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_window_conv;

  localparam int N   = 9;
  localparam int CW  = 10;
  localparam int PXW = 30;
  localparam int CFW = 8;
  localparam int TDW = 32;
`ifdef WINDOW_CONV_ROUND_EN
  localparam int RND_EXP = 2;
`else
  localparam int RND_EXP = 1;
`endif

  logic clk = 1'b0;
  logic rst_i;
  logic [N*CFW-1:0] coef_i;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(N*PXW)) win_if ();
  axi4_stream_if #(.DATA_WIDTH(TDW))   vid_if ();

  window_conv #(
    .WIN_SIZE(3), .COMP_NUM(3), .COMP_WIDTH(CW), .PX_WIDTH(PXW),
    .COEF_WIDTH(CFW), .NORM_SHIFT(4), .TDATA_WIDTH(TDW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .coef_i  (coef_i),
    .window_i(win_if),
    .video_o (vid_if)
  );

  typedef struct packed {
    logic [TDW-1:0] d;
    logic           l;
    logic           u;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_rdy = 1'b0;
  int   G  [N] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  int   ID [N] = '{0, 0, 0, 0, 16, 0, 0, 0, 0};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [N*CFW-1:0] mk_coef(input int w [N]);
    logic [N*CFW-1:0] r;
    for (int k = 0; k < N; k++) r[k*CFW +: CFW] = CFW'(w[k]);
    return r;
  endfunction

  function automatic logic [N*PXW-1:0] win_u(input int v [N]);
    logic [N*PXW-1:0] r;
    for (int k = 0; k < N; k++)
      for (int c = 0; c < 3; c++) r[k*PXW + c*CW +: CW] = CW'(v[k]);
    return r;
  endfunction

  function automatic logic [TDW-1:0] px_out(input int v);
    return {2'b00, CW'(v), CW'(v), CW'(v)};
  endfunction

  // Output ready pattern changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    vid_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  exp_t held;
  bit   stalled = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {vid_if.tvalid, vid_if.tdata, vid_if.tlast, vid_if.tuser}, {1'b1, held});
      stalled = 1'b0;
      if (vid_if.tvalid) begin
        if (vid_if.tready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h expected no output", vid_if.tdata);
          end else begin
            e = sb.pop_front();
            chk("out_data", vid_if.tdata, e.d);
            chk("out_last", vid_if.tlast, e.l);
            chk("out_user", vid_if.tuser, e.u);
          end
        end else begin
          stalled = 1'b1;
          held    = {vid_if.tdata, vid_if.tlast, vid_if.tuser};
        end
      end
    end
  end

  task automatic send(input logic [N*PXW-1:0] d, input bit l, input bit u, input logic [TDW-1:0] e);
    exp_t x;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    win_if.tdata  = d;
    win_if.tlast  = l;
    win_if.tuser  = u;
    win_if.tvalid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (win_if.tready) begin
        x.d = e; x.l = l; x.u = u;
        sb.push_back(x);
        @(posedge clk);
        #1;
        win_if.tvalid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no tready expected tready within 200 cycles");
      win_if.tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && sb.size() > 0; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int lat;
    logic [N*PXW-1:0] rw;
    rst_i          = 1'b1;
    coef_i         = '0;
    win_if.tdata   = '0;
    win_if.tvalid  = 1'b0;
    win_if.tlast   = 1'b0;
    win_if.tuser   = 1'b0;
    vid_if.tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", vid_if.tvalid, 0);
    chk("rst_tdata",  vid_if.tdata,  0);
    chk("rst_tlast",  vid_if.tlast,  0);
    chk("rst_tuser",  vid_if.tuser,  0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("tready_after_rst", win_if.tready, 1);

    // Gaussian on uniform 100, with latency measurement.
    coef_i = mk_coef(G);
    send(win_u('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 1'b0, 1'b1, px_out(100));
    lat = 0;
    while (!vid_if.tvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 6);
    send(win_u('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 1'b1, 1'b0, px_out(100));

    // Clamping.
    coef_i = mk_coef('{1, 1, 1, 1, -8, 1, 1, 1, 1});
    send(win_u('{0, 0, 0, 0, 1023, 0, 0, 0, 0}), 1'b0, 1'b1, px_out(0));
    coef_i = mk_coef(ID);
    send(win_u('{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023}), 1'b0, 1'b1, px_out(1023));
    coef_i = mk_coef('{16, 16, 16, 16, 16, 16, 16, 16, 16});
    send(win_u('{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023}), 1'b1, 1'b1, px_out(1023));

    // Rounding: sum 24 >> 4.
    coef_i = mk_coef('{0, 0, 0, 0, 3, 0, 0, 0, 0});
    send(win_u('{0, 0, 0, 0, 8, 0, 0, 0, 0}), 1'b1, 1'b1, px_out(RND_EXP));

    // Kernel change mid-frame only takes effect at the next tuser beat.
    coef_i = mk_coef(G);
    send(win_u('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 1'b0, 1'b1, px_out(100));
    coef_i = mk_coef(ID);
    send(win_u('{160, 160, 160, 160, 0, 160, 160, 160, 160}), 1'b0, 1'b0, px_out(120));
    send(win_u('{160, 160, 160, 160, 0, 160, 160, 160, 160}), 1'b1, 1'b0, px_out(120));
    send(win_u('{160, 160, 160, 160, 0, 160, 160, 160, 160}), 1'b0, 1'b1, px_out(0));
    drain();

    // Identity on random windows with random output backpressure.
    rand_rdy = 1'b1;
    coef_i   = mk_coef(ID);
    for (int b = 0; b < 24; b++) begin
      for (int k = 0; k < N; k++)
        for (int c = 0; c < 3; c++) rw[k*PXW + c*CW +: CW] = CW'($urandom_range(0, 1023));
      send(rw, (b % 6) == 5, b == 0, {2'b00, rw[4*PXW +: PXW]});
    end
    drain();
    rand_rdy = 1'b0;

    // Reset with windows in flight.
    coef_i = mk_coef(G);
    for (int b = 0; b < 8; b++)
      send(win_u('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 1'b0, b == 0, px_out(100));
    #2;
    rst_i = 1'b1;
    sb.delete();
    #1;
    chk("rst_mid_tvalid", vid_if.tvalid, 0);
    chk("rst_mid_tdata",  vid_if.tdata,  0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("tready_after_rst2", win_if.tready, 1);
    // Kernel register was cleared, so a non-tuser beat yields zero.
    send(win_u('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 1'b0, 1'b0, px_out(0));
    send(win_u('{100, 100, 100, 100, 100, 100, 100, 100, 100}), 1'b0, 1'b1, px_out(100));
    send(win_u('{160, 160, 160, 160, 0, 160, 160, 160, 160}), 1'b1, 1'b0, px_out(120));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
